hsynth_capture_dma_ctrl: RTL and testbench

Schedules SoCFPGA DMA requests that drain the synth audio capture FIFO, choosing between burst requests and single requests based on FIFO fill level and an idle timeout. It sits between the capture FIFO status outputs and the HPS DMA request/ack lines, replacing a plain "not-empty" single-request scheme. It also keeps sticky overflow/protocol error flags and request counters for the APB status space.

---
 rtl/hsynth_capture_dma_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hsynth_capture_dma_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsynth_capture_dma_ctrl.sv
// hsynth_capture_dma_ctrl: schedules burst/single DMA requests that drain the
// synth audio capture FIFO, and keeps sticky error flags and request counters.
module hsynth_capture_dma_ctrl #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned TMO_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [TMO_W-1:0]   timeout_cycles,
  input  logic [FIFO_AW:0]   fifo_used,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic               fifo_wr,
  input  logic               fifo_rd,
  input  logic               dma_ack,
  output logic               dma_req,
  output logic               dma_single,
  output logic               busy,
  output logic               ovf_sticky,
  output logic               err_sticky,
  output logic [15:0]        burst_cnt,
  output logic [15:0]        single_cnt
);

  localparam int unsigned CW           = FIFO_AW + 1;
  localparam logic [CW-1:0] BURST_LEN_C  = CW'(BURST_LEN);
  localparam logic [CW-1:0] SINGLE_LEN_C = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BREQ = 2'd1,
    ST_SREQ = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_n;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_n;
  logic               hold_q, hold_n;
  logic               dma_req_n, dma_single_n, busy_n;
  logic               ovf_n, err_n;
  logic [15:0]        burst_cnt_n, single_cnt_n;

  logic [CW-1:0]      rd_inc;
  logic               burst_go;
  logic               tmo_elig;
  logic               tmo_hit;

  // Request qualifiers; read count includes the current cycle's pop and saturates
  always_comb begin
    rd_inc   = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + CW'(fifo_rd);
    burst_go = enable && (fifo_used >= BURST_LEN_C);
    tmo_elig = enable && !fifo_empty && (fifo_used < BURST_LEN_C);
    tmo_hit  = enable && !fifo_empty && (timeout_cycles != '0) &&
               (tmo_cnt_q >= (timeout_cycles - TMO_W'(1)));
  end

  // Next-state and registered-output logic; clear overrides everything
  always_comb begin
    state_n      = state_q;
    tmo_cnt_n    = '0;
    rd_cnt_n     = '0;
    hold_n       = 1'b0;
    dma_req_n    = 1'b0;
    dma_single_n = 1'b0;
    ovf_n        = ovf_sticky | (fifo_wr & fifo_full);
    err_n        = err_sticky;
    burst_cnt_n  = burst_cnt;
    single_cnt_n = single_cnt;

    unique case (state_q)
      ST_IDLE: begin
        if (dma_ack) err_n = 1'b1;
        if (burst_go) begin
          state_n   = ST_BREQ;
          dma_req_n = 1'b1;
        end else if (tmo_hit) begin
          state_n      = ST_SREQ;
          dma_single_n = 1'b1;
        end else if (tmo_elig) begin
          tmo_cnt_n = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_BREQ: begin
        rd_cnt_n = rd_inc;
        if (dma_ack) begin
          state_n     = ST_HOLD;
          rd_cnt_n    = '0;
          burst_cnt_n = burst_cnt + 16'd1;
          if (rd_inc != BURST_LEN_C) err_n = 1'b1;
        end else begin
          dma_req_n = 1'b1;
        end
      end
      ST_SREQ: begin
        rd_cnt_n = rd_inc;
        if (dma_ack) begin
          state_n      = ST_HOLD;
          rd_cnt_n     = '0;
          single_cnt_n = single_cnt + 16'd1;
          if (rd_inc != SINGLE_LEN_C) err_n = 1'b1;
        end else begin
          dma_single_n = 1'b1;
        end
      end
      ST_HOLD: begin
        if (dma_ack) err_n = 1'b1;
        // Two cycles of hold cover the FIFO status latency
        if (hold_q) state_n = ST_IDLE;
        else        hold_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (clear) begin
      state_n      = ST_IDLE;
      tmo_cnt_n    = '0;
      rd_cnt_n     = '0;
      hold_n       = 1'b0;
      dma_req_n    = 1'b0;
      dma_single_n = 1'b0;
      ovf_n        = 1'b0;
      err_n        = 1'b0;
      burst_cnt_n  = '0;
      single_cnt_n = '0;
    end

    busy_n = (state_n != ST_IDLE);
  end

  // State, counters and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tmo_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      hold_q     <= 1'b0;
      dma_req    <= 1'b0;
      dma_single <= 1'b0;
      busy       <= 1'b0;
      ovf_sticky <= 1'b0;
      err_sticky <= 1'b0;
      burst_cnt  <= '0;
      single_cnt <= '0;
    end else begin
      state_q    <= state_n;
      tmo_cnt_q  <= tmo_cnt_n;
      rd_cnt_q   <= rd_cnt_n;
      hold_q     <= hold_n;
      dma_req    <= dma_req_n;
      dma_single <= dma_single_n;
      busy       <= busy_n;
      ovf_sticky <= ovf_n;
      err_sticky <= err_n;
      burst_cnt  <= burst_cnt_n;
      single_cnt <= single_cnt_n;
    end
  end

endmodule

// File: tb/tb_hsynth_capture_dma_ctrl.sv
// Scoreboard bench for hsynth_capture_dma_ctrl.
module tb_hsynth_capture_dma_ctrl;

  localparam int ID_REQ = 0, ID_SGL = 1, ID_BUSY = 2, ID_OVF = 3,
                 ID_ERR = 4, ID_BCNT = 5, ID_SCNT = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, clear, fifo_empty, fifo_full, fifo_wr, fifo_rd, dma_ack;
  logic [15:0] timeout_cycles;
  logic [4:0]  fifo_used;
  logic        dma_req, dma_single, busy, ovf_sticky, err_sticky;
  logic [15:0] burst_cnt, single_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hsynth_capture_dma_ctrl #(.BURST_LEN(8), .FIFO_AW(4), .TMO_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .timeout_cycles(timeout_cycles), .fifo_used(fifo_used),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd), .dma_ack(dma_ack), .dma_req(dma_req),
    .dma_single(dma_single), .busy(busy), .ovf_sticky(ovf_sticky),
    .err_sticky(err_sticky), .burst_cnt(burst_cnt), .single_cnt(single_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int id);
    case (id)
      ID_REQ:  return 32'(dma_req);
      ID_SGL:  return 32'(dma_single);
      ID_BUSY: return 32'(busy);
      ID_OVF:  return 32'(ovf_sticky);
      ID_ERR:  return 32'(err_sticky);
      ID_BCNT: return 32'(burst_cnt);
      ID_SCNT: return 32'(single_cnt);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int id, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.id = id; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs_of(e.id), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rise(input int id, input int maxc, output int cyc);
    cyc = 0;
    while (obs_of(id) != 32'd1 && cyc < maxc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_rd = 1'b1;
      tick();
    end
    fifo_rd = 1'b0;
  endtask

  // Burst and single requests must never overlap
  always @(negedge clk)
    if (reset_n && (dma_req & dma_single)) check_eq("req_exclusive", 32'd1, 32'd0);

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; timeout_cycles = '0;
    fifo_used = '0; fifo_empty = 1'b1; fifo_full = 1'b0; fifo_wr = 1'b0;
    fifo_rd = 1'b0; dma_ack = 1'b0;
    ticks(2);
    expect_out("rst_req", ID_REQ, 0);   expect_out("rst_sgl", ID_SGL, 0);
    expect_out("rst_busy", ID_BUSY, 0); expect_out("rst_ovf", ID_OVF, 0);
    expect_out("rst_err", ID_ERR, 0);   expect_out("rst_bcnt", ID_BCNT, 0);
    expect_out("rst_scnt", ID_SCNT, 0);
    drain();
    reset_n = 1'b1;
    tick();

    // Burst: 7 reads, 8th read coincides with ack
    enable = 1'b1; fifo_used = 5'd8; fifo_empty = 1'b0;
    tick();
    expect_out("b_req", ID_REQ, 1); expect_out("b_sgl", ID_SGL, 0);
    expect_out("b_busy", ID_BUSY, 1);
    drain();
    reads(7);
    expect_out("b_req_held", ID_REQ, 1);
    drain();
    fifo_rd = 1'b1; dma_ack = 1'b1;
    tick();
    fifo_rd = 1'b0; dma_ack = 1'b0;
    expect_out("b_drop", ID_REQ, 0); expect_out("b_bcnt", ID_BCNT, 1);
    expect_out("b_err", ID_ERR, 0);
    drain();
    // FIFO stays at 8: next request exactly 3 edges after the ack edge
    tick(); expect_out("sp_a1", ID_REQ, 0); drain();
    tick(); expect_out("sp_a2", ID_REQ, 0); drain();
    tick(); expect_out("sp_a3", ID_REQ, 1); drain();
    reads(8);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0; fifo_used = '0; fifo_empty = 1'b1;
    expect_out("b2_bcnt", ID_BCNT, 2); expect_out("b2_err", ID_ERR, 0);
    drain();
    ticks(3);
    expect_out("b2_idle", ID_BUSY, 0);
    drain();

    // Timeout single with T=10
    timeout_cycles = 16'd10; fifo_used = 5'd3; fifo_empty = 1'b0;
    wait_rise(ID_SGL, 40, cyc);
    check_eq("tmo_latency", 32'(cyc), 32'd10);
    expect_out("tmo_noreq", ID_REQ, 0);
    drain();
    reads(1);
    fifo_used = 5'd2;
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0; fifo_used = '0; fifo_empty = 1'b1;
    expect_out("s_drop", ID_SGL, 0); expect_out("s_scnt", ID_SCNT, 1);
    expect_out("s_err", ID_ERR, 0);  expect_out("s_bcnt", ID_BCNT, 2);
    drain();
    ticks(3);

    // Short burst then clear
    timeout_cycles = '0; fifo_used = 5'd8; fifo_empty = 1'b0;
    tick();
    expect_out("sb_req", ID_REQ, 1);
    drain();
    reads(6);
    fifo_used = '0; fifo_empty = 1'b1; dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    expect_out("sb_err", ID_ERR, 1); expect_out("sb_bcnt", ID_BCNT, 3);
    drain();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_out("clr_err", ID_ERR, 0);   expect_out("clr_bcnt", ID_BCNT, 0);
    expect_out("clr_scnt", ID_SCNT, 0); expect_out("clr_busy", ID_BUSY, 0);
    drain();

    // Disable mid-request: request held until ack, none afterwards
    fifo_used = 5'd16; fifo_empty = 1'b0;
    tick();
    expect_out("dis_req", ID_REQ, 1);
    drain();
    enable = 1'b0;
    ticks(3);
    expect_out("dis_held", ID_REQ, 1);
    drain();
    reads(8);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    expect_out("dis_drop", ID_REQ, 0); expect_out("dis_bcnt", ID_BCNT, 1);
    expect_out("dis_err", ID_ERR, 0);
    drain();
    ticks(4);
    expect_out("dis_noreq", ID_REQ, 0); expect_out("dis_nosgl", ID_SGL, 0);
    expect_out("dis_busy", ID_BUSY, 0);
    drain();

    // Clear and ack in the same cycle, then a spurious ack
    enable = 1'b1;
    tick();
    expect_out("ca_req", ID_REQ, 1);
    drain();
    fifo_used = '0; fifo_empty = 1'b1; clear = 1'b1; dma_ack = 1'b1;
    tick();
    clear = 1'b0; dma_ack = 1'b0;
    expect_out("ca_req0", ID_REQ, 0); expect_out("ca_busy", ID_BUSY, 0);
    expect_out("ca_bcnt", ID_BCNT, 0); expect_out("ca_err", ID_ERR, 0);
    drain();
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    expect_out("spur_err", ID_ERR, 1); expect_out("spur_busy", ID_BUSY, 0);
    drain();

    // Overflow, then asynchronous reset during a single request
    fifo_full = 1'b1; fifo_wr = 1'b1;
    tick();
    fifo_full = 1'b0; fifo_wr = 1'b0;
    expect_out("ovf", ID_OVF, 1);
    drain();
    timeout_cycles = 16'd2; fifo_used = 5'd1; fifo_empty = 1'b0;
    wait_rise(ID_SGL, 20, cyc);
    check_eq("rs_sgl_up", obs_of(ID_SGL), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    expect_out("ar_req", ID_REQ, 0);   expect_out("ar_sgl", ID_SGL, 0);
    expect_out("ar_busy", ID_BUSY, 0); expect_out("ar_ovf", ID_OVF, 0);
    expect_out("ar_err", ID_ERR, 0);   expect_out("ar_bcnt", ID_BCNT, 0);
    expect_out("ar_scnt", ID_SCNT, 0);
    drain();
    #1 reset_n = 1'b1;
    tick();

    // Lowering the timeout below the running count fires on the next cycle
    timeout_cycles = 16'd20; fifo_used = 5'd2; fifo_empty = 1'b0;
    ticks(6);
    expect_out("lt_wait", ID_SGL, 0);
    drain();
    timeout_cycles = 16'd3;
    tick();
    expect_out("lt_fire", ID_SGL, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
